// File: rtl/axim_bridge_if.sv
// LSU external-memory handshake plus AXI4-Lite master channels for axim_bridge.
// The master modport is the bridge's view; slave is the LSU/interconnect side.
interface axim_bridge_if;
  logic        hs_ls4axim_val;
  logic        hs_axim4ls_rdy;
  logic [31:0] i_adr;
  logic [31:0] i_wdat;
  logic [3:0]  i_wen;
  logic        i_ren;
  logic [31:0] o_rdat;
  logic        o_err;

  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [2:0]  m_awprot;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [2:0]  m_arprot;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  modport master (
    input  hs_ls4axim_val, i_adr, i_wdat, i_wen, i_ren,
    output hs_axim4ls_rdy, o_rdat, o_err,
    output m_awaddr, m_awvalid, m_awprot, m_wdata, m_wstrb, m_wvalid, m_bready,
    output m_araddr, m_arvalid, m_arprot, m_rready,
    input  m_awready, m_wready, m_bresp, m_bvalid,
    input  m_arready, m_rdata, m_rresp, m_rvalid
  );

  modport slave (
    output hs_ls4axim_val, i_adr, i_wdat, i_wen, i_ren,
    input  hs_axim4ls_rdy, o_rdat, o_err,
    input  m_awaddr, m_awvalid, m_awprot, m_wdata, m_wstrb, m_wvalid, m_bready,
    input  m_araddr, m_arvalid, m_arprot, m_rready,
    output m_awready, m_wready, m_bresp, m_bvalid,
    output m_arready, m_rdata, m_rresp, m_rvalid
  );
endinterface

// File: rtl/axim_bridge.sv
// Bridges single-beat LSU requests onto one AXI4-Lite master transaction each,
// returning read data / error with a one-cycle rdy pulse; stalled phases time out.
module axim_bridge #(
  parameter int unsigned TO_CYCLES = 255,
  parameter int unsigned TO_W      = 8
) (
  input logic         clk,
  input logic         rst,
  axim_bridge_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, DONE} state_t;

  // Counter value seen during the last permitted wait cycle of a phase.
  localparam logic [TO_W-1:0] TO_LAST = (TO_CYCLES == 0) ? '0 : TO_W'(TO_CYCLES - 1);

  state_t          state, state_nx;
  logic [TO_W-1:0] cnt, cnt_nx;
  logic [31:0]     adr_q, adr_nx, wdat_q, wdat_nx, rdat_q, rdat_nx;
  logic [3:0]      wen_q, wen_nx;
  logic            aw_done, aw_done_nx, w_done, w_done_nx;
  logic            arvalid_q, arvalid_nx, rready_q, rready_nx;
  logic            awvalid_q, awvalid_nx, wvalid_q, wvalid_nx, bready_q, bready_nx;
  logic            rdy_q, rdy_nx, err_q, err_nx;
  logic            to_hit_c, abort_c, aw_fin_c, w_fin_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      adr_q     <= '0;
      wdat_q    <= '0;
      wen_q     <= '0;
      rdat_q    <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      adr_q     <= adr_nx;
      wdat_q    <= wdat_nx;
      wen_q     <= wen_nx;
      rdat_q    <= rdat_nx;
      aw_done   <= aw_done_nx;
      w_done    <= w_done_nx;
      arvalid_q <= arvalid_nx;
      rready_q  <= rready_nx;
      awvalid_q <= awvalid_nx;
      wvalid_q  <= wvalid_nx;
      bready_q  <= bready_nx;
      rdy_q     <= rdy_nx;
      err_q     <= err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + TO_W'(1);
    adr_nx     = adr_q;
    wdat_nx    = wdat_q;
    wen_nx     = wen_q;
    rdat_nx    = rdat_q;
    aw_done_nx = aw_done;
    w_done_nx  = w_done;
    arvalid_nx = arvalid_q;
    rready_nx  = rready_q;
    awvalid_nx = awvalid_q;
    wvalid_nx  = wvalid_q;
    bready_nx  = bready_q;
    rdy_nx     = 1'b0;
    err_nx     = err_q;
    abort_c    = 1'b0;
    to_hit_c   = (TO_CYCLES != 0) && (cnt == TO_LAST);
    aw_fin_c   = aw_done | bus.m_awready;
    w_fin_c    = w_done | bus.m_wready;

    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (bus.hs_ls4axim_val) begin
          adr_nx  = bus.i_adr;
          wdat_nx = bus.i_wdat;
          wen_nx  = bus.i_wen;
          if (bus.i_wen != 4'b0000) begin
            state_nx   = WR_AW;
            awvalid_nx = 1'b1;
            wvalid_nx  = 1'b1;
            aw_done_nx = 1'b0;
            w_done_nx  = 1'b0;
          end else if (bus.i_ren) begin
            state_nx   = RD_A;
            arvalid_nx = 1'b1;
          end else begin
            state_nx = DONE;
            rdy_nx   = 1'b1;
            rdat_nx  = '0;
            err_nx   = 1'b0;
          end
        end
      end
      RD_A: begin
        if (bus.m_arready) begin
          state_nx   = RD_D;
          arvalid_nx = 1'b0;
          rready_nx  = 1'b1;
          cnt_nx     = '0;
        end else if (to_hit_c) begin
          abort_c = 1'b1;
        end
      end
      RD_D: begin
        if (bus.m_rvalid) begin
          state_nx  = DONE;
          rready_nx = 1'b0;
          rdy_nx    = 1'b1;
          rdat_nx   = bus.m_rdata;
          err_nx    = (bus.m_rresp != 2'b00);
        end else if (to_hit_c) begin
          abort_c = 1'b1;
        end
      end
      WR_AW: begin
        // Address and data channels retire independently, possibly together.
        if (!aw_done && bus.m_awready) begin
          awvalid_nx = 1'b0;
          aw_done_nx = 1'b1;
        end
        if (!w_done && bus.m_wready) begin
          wvalid_nx = 1'b0;
          w_done_nx = 1'b1;
        end
        if (aw_fin_c && w_fin_c) begin
          state_nx  = WR_B;
          bready_nx = 1'b1;
          cnt_nx    = '0;
        end else if (to_hit_c) begin
          abort_c = 1'b1;
        end
      end
      WR_B: begin
        if (bus.m_bvalid) begin
          state_nx  = DONE;
          bready_nx = 1'b0;
          rdy_nx    = 1'b1;
          rdat_nx   = '0;
          err_nx    = (bus.m_bresp != 2'b00);
        end else if (to_hit_c) begin
          abort_c = 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    // Abandon the stalled phase: release the bus and report an error.
    if (abort_c) begin
      state_nx   = DONE;
      arvalid_nx = 1'b0;
      rready_nx  = 1'b0;
      awvalid_nx = 1'b0;
      wvalid_nx  = 1'b0;
      bready_nx  = 1'b0;
      rdy_nx     = 1'b1;
      err_nx     = 1'b1;
      rdat_nx    = '0;
    end
  end

  assign bus.hs_axim4ls_rdy = rdy_q;
  assign bus.o_rdat         = rdat_q;
  assign bus.o_err          = err_q;
  assign bus.m_awaddr       = adr_q;
  assign bus.m_awvalid      = awvalid_q;
  assign bus.m_awprot       = 3'b000;
  assign bus.m_wdata        = wdat_q;
  assign bus.m_wstrb        = wen_q;
  assign bus.m_wvalid       = wvalid_q;
  assign bus.m_bready       = bready_q;
  assign bus.m_araddr       = adr_q;
  assign bus.m_arvalid      = arvalid_q;
  assign bus.m_arprot       = 3'b000;
  assign bus.m_rready       = rready_q;

endmodule
